shift_cnt_gen: RTL and testbench
================================

SHIFT_CNT_GEN -- requirements
Module: shift_cnt_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width (legal range 2..32).
REQ-002 SHALL have parameter MODE, default 0, 0 = Johnson (2*WIDTH states), 1 = ring/one-hot (WIDTH states).
REQ-003 SHALL have parameter SELF_CORRECT, default 1, 1 = return illegal states to the reset state.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL provide n_rst  in  1  asynchronous active-low reset.
REQ-006 SHALL provide en  in  1  advance one state per enabled cycle.
REQ-007 SHALL provide dir  in  1  0 = forward, 1 = reverse.
REQ-008 SHALL provide clr  in  1  synchronous return to the reset state.
REQ-009 SHALL provide load  in  1  synchronous load request.
REQ-010 SHALL provide load_val  in  WIDTH  value to load.
REQ-011 SHALL provide q  out  WIDTH  registered counter state.
REQ-012 SHALL provide idx  out  IDX_W  registered state index, IDX_W = clog2(2*WIDTH).
REQ-013 SHALL provide wrap  out  1  one-cycle pulse on wrap-around.
REQ-014 SHALL provide err  out  1  sticky error flag.

Function
REQ-015 SHALL step Johnson forward as q <= {q[WIDTH-2:0], ~q[WIDTH-1]}, and Johnson reverse as q <= {~q[0], q[WIDTH-1:1]}.
REQ-016 SHALL step ring forward as q <= {q[WIDTH-2:0], q[WIDTH-1]}, and ring reverse as q <= {q[0], q[WIDTH-1:1]}.
REQ-017 SHALL apply priority per cycle: clr > load > illegal-state correction > en step > hold.
REQ-018 SHALL treat a Johnson state as legal iff adjacent-bit transitions (q[i] != q[i+1], i = 0..WIDTH-2) number at most 1; a ring state is legal iff popcount == 1.
REQ-019 SHALL compute Johnson idx as popcount(q) when q[WIDTH-1] = 0, else 2*WIDTH - popcount(q); ring idx is the position of the set bit.
REQ-020 SHALL update q and idx in the same cycle, so idx matches q with zero added latency.
REQ-021 SHALL pulse wrap for one cycle, coincident with q, when an en step moves idx from the last state to 0 (forward) or from 0 to the last state (reverse); clr, load and correction never raise wrap.
REQ-022 SHALL ignore an illegal load_val, leaving q unchanged and setting err; a legal load_val is taken the next cycle.
REQ-023 SHALL, with SELF_CORRECT = 1, check q every cycle regardless of en; an illegal q sets err and is replaced by the reset state on the next clock.
REQ-024 SHALL, with SELF_CORRECT = 0, set err on an illegal q and continue stepping the illegal pattern.
REQ-025 SHALL clear err only on clr or reset; a clr and a new error in the same cycle leave err = 0.
REQ-026 SHALL let a dir change take effect on the same enabled edge, with no dead cycle.

Reset
REQ-027 SHALL reset asynchronously on n_rst low to q = all-zero (Johnson) or 0...01 (ring), idx = 0, wrap = 0, err = 0.
REQ-028 SHALL treat an n_rst assertion mid-count as overriding all inputs immediately; the first enabled edge after release steps from the reset state.

Structure
REQ-029 SHALL place the MODE_JOHNSON/MODE_RING constants, the reset-state function and the IDX_W width function in package shift_cnt_pkg.
REQ-030 SHALL implement legality check and idx decode in one combinational sub-module, shift_cnt_dec, instanced once for q and once for load_val (legality only).

Verification
REQ-031 SHALL cover, for Johnson W=4: reset, then en=1, dir=0 for 8 cycles -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; idx = 1..7, 0; wrap = 1 only on the 8th cycle.
REQ-032 SHALL cover, for Johnson W=4: from 0000, dir=1, en=1 -> q = 1000, idx = 7, wrap = 1; next q = 1100, idx = 6, wrap = 0.
REQ-033 SHALL cover, for Johnson W=4: load = 1 with load_val = 0110 -> q unchanged, err = 1; then load_val = 1110 -> q = 1110, idx = 5; then clr -> q = 0000, err = 0.
REQ-034 SHALL cover, for Johnson W=4 with SELF_CORRECT = 1: force q = 0101 with en = 0 -> next cycle q = 0000, err = 1, wrap = 0.
REQ-035 SHALL cover, for ring W=4: reset -> q = 0001; 4 forward steps -> 0010, 0100, 1000, 0001 with wrap on the 4th; clr and load in the same cycle -> q = 0001.
REQ-036 SHALL cover, for Johnson W=4: n_rst pulsed low mid-count at q = 0111 -> q = 0000 and idx = 0 asynchronously, with no wrap.

Source files
------------

// File: rtl/shift_cnt_pkg.sv
// Shared constants and helpers for the shift-register counter generator.
//   MODE_JOHNSON / MODE_RING : values of the MODE parameter
//   idx_w(width)             : width of the state index, clog2(2*width)
//   reset_state(mode)        : reset pattern (LSB-aligned, caller truncates)
package shift_cnt_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    function automatic int idx_w(input int width);
        return $clog2(2 * width);
    endfunction

    // Johnson counters start from all zeros, ring counters from a single
    // hot bit in position 0.
    function automatic logic [31:0] reset_state(input int mode);
        return (mode == MODE_RING) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/shift_cnt_gen_if.sv
// Control/status bundle of shift_cnt_gen.
//   master : drives en, dir, clr, load, load_val; observes q, idx, wrap, err
//   slave  : the counter itself
interface shift_cnt_gen_if
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int IDX_W = idx_w(WIDTH);

    logic             en;
    logic             dir;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             err;

    modport master (
        output en, dir, clr, load, load_val,
        input  q, idx, wrap, err
    );

    modport slave (
        input  en, dir, clr, load, load_val,
        output q, idx, wrap, err
    );

endinterface

// File: rtl/shift_cnt_dec.sv
// Combinational legality check and state-index decode for one counter
// pattern.
//   val   : pattern to examine
//   legal : Johnson - at most one adjacent-bit transition; ring - one-hot
//   idx   : position of the pattern in the counting sequence
module shift_cnt_dec
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] val,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    int trans;
    int pc;
    int pos;

    always_comb begin
        trans = 0;
        pc    = 0;
        pos   = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (val[i] != val[i+1]) trans = trans + 1;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (val[i]) pc = pc + 1;
        end
        // Lowest set bit; only meaningful when the ring pattern is one-hot.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (val[i]) pos = i;
        end

        if (MODE == MODE_RING) begin
            legal = (pc == 1);
            idx   = IDX_W'(pos);
        end else begin
            legal = (trans <= 1);
            // Filling phase counts ones up; draining phase (MSB set) counts
            // the remaining ones back down from 2*WIDTH.
            idx   = val[WIDTH-1] ? IDX_W'(2 * WIDTH - pc) : IDX_W'(pc);
        end
    end

endmodule

// File: rtl/shift_cnt_gen.sv
// Johnson / ring shift-register counter with load, clear, direction control,
// wrap pulse and sticky error flag.
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   bus   : slave side of shift_cnt_gen_if (en, dir, clr, load, load_val in;
//           q, idx, wrap, err out)
// Per-cycle priority: clr > load > illegal-state correction > step > hold.
module shift_cnt_gen
    import shift_cnt_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int MODE         = MODE_JOHNSON,
    parameter int SELF_CORRECT = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    shift_cnt_gen_if.slave  bus
);

    localparam int               IDX_W    = idx_w(WIDTH);
    localparam int               N_STATES = (MODE == MODE_RING) ? WIDTH : 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STATES - 1);
    localparam logic [WIDTH-1:0] Q_RST    = WIDTH'(reset_state(MODE));

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_step;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             err_r;
    logic             err_nxt;
    logic             q_legal;
    logic [IDX_W-1:0] q_idx;
    logic             ld_legal;
    logic [IDX_W-1:0] ld_idx_unused;

    shift_cnt_dec #(.WIDTH(WIDTH), .MODE(MODE)) u_dec_q (
        .val   (q_r),
        .legal (q_legal),
        .idx   (q_idx)
    );

    shift_cnt_dec #(.WIDTH(WIDTH), .MODE(MODE)) u_dec_ld (
        .val   (bus.load_val),
        .legal (ld_legal),
        .idx   (ld_idx_unused)
    );

    always_comb begin
        q_step = q_r;
        if (MODE == MODE_RING) begin
            q_step = bus.dir ? {q_r[0], q_r[WIDTH-1:1]}
                             : {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        end else begin
            q_step = bus.dir ? {~q_r[0], q_r[WIDTH-1:1]}
                             : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        end
    end

    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        // An illegal current pattern is flagged whatever else happens,
        // unless clr wipes the flag this cycle.
        err_nxt  = err_r | ~q_legal;

        if (bus.clr) begin
            q_nxt   = Q_RST;
            err_nxt = 1'b0;
        end else if (bus.load) begin
            if (ld_legal) q_nxt = bus.load_val;
            else          err_nxt = 1'b1;
        end else if (!q_legal && (SELF_CORRECT != 0)) begin
            q_nxt = Q_RST;
        end else if (bus.en) begin
            q_nxt = q_step;
            // Wrap is judged on the index before the step; an illegal
            // pattern left to run has no meaningful wrap point.
            if (q_legal) begin
                wrap_nxt = bus.dir ? (q_idx == '0) : (q_idx == IDX_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_r    <= Q_RST;
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
            err_r  <= err_nxt;
        end
    end

    // idx is a pure decode of the q register, so it tracks q exactly.
    assign bus.q    = q_r;
    assign bus.idx  = q_idx;
    assign bus.wrap = wrap_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_shift_cnt_gen.sv
// Directed bench for shift_cnt_gen: a Johnson W=4 instance and a ring W=4
// instance, each driven from a table of {inputs, expected outputs}, plus
// hand-written sequences for forced-illegal-state and mid-count reset.
module tb_shift_cnt_gen;
    import shift_cnt_pkg::*;

    typedef struct {
        logic       en;
        logic       dir;
        logic       clr;
        logic       load;
        logic [3:0] ld;
        logic [3:0] q;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } vec_t;

    logic clk;
    logic n_rst;
    int   tests;
    int   fails;

    shift_cnt_gen_if #(.WIDTH(4)) bus_j ();
    shift_cnt_gen_if #(.WIDTH(4)) bus_r ();

    shift_cnt_gen #(.WIDTH(4), .MODE(MODE_JOHNSON), .SELF_CORRECT(1)) dut_j (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_j.slave)
    );

    shift_cnt_gen #(.WIDTH(4), .MODE(MODE_RING), .SELF_CORRECT(1)) dut_r (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_r.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_j(input vec_t v);
        bus_j.en = v.en; bus_j.dir = v.dir; bus_j.clr = v.clr;
        bus_j.load = v.load; bus_j.load_val = v.ld;
    endtask

    task automatic drive_r(input vec_t v);
        bus_r.en = v.en; bus_r.dir = v.dir; bus_r.clr = v.clr;
        bus_r.load = v.load; bus_r.load_val = v.ld;
    endtask

    vec_t jv[$];
    vec_t rv[$];
    vec_t idle;

    initial begin
        tests = 0;
        fails = 0;
        idle  = '{0, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0};

        // Johnson: 8 forward steps, reverse, dir flip, loads, clears.
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0001, 3'd1, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0011, 3'd2, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0111, 3'd3, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1111, 3'd4, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1110, 3'd5, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1000, 3'd7, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0});
        jv.push_back('{1, 1, 0, 0, 4'b0000, 4'b1000, 3'd7, 1, 0});
        jv.push_back('{1, 1, 0, 0, 4'b0000, 4'b1100, 3'd6, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1000, 3'd7, 0, 0});
        jv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0});
        jv.push_back('{0, 0, 0, 0, 4'b0000, 4'b0000, 3'd0, 0, 0});
        jv.push_back('{0, 0, 0, 1, 4'b0110, 4'b0000, 3'd0, 0, 1});
        jv.push_back('{0, 0, 0, 1, 4'b1110, 4'b1110, 3'd5, 0, 1});
        jv.push_back('{1, 0, 0, 1, 4'b0011, 4'b0011, 3'd2, 0, 1});
        jv.push_back('{1, 0, 1, 0, 4'b0000, 4'b0000, 3'd0, 0, 0});
        jv.push_back('{1, 0, 1, 1, 4'b0111, 4'b0000, 3'd0, 0, 0});
        jv.push_back('{1, 0, 1, 1, 4'b0101, 4'b0000, 3'd0, 0, 0});

        // Ring: 4 forward steps, reverse wrap, loads, clr over load.
        rv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0010, 3'd1, 0, 0});
        rv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0100, 3'd2, 0, 0});
        rv.push_back('{1, 0, 0, 0, 4'b0000, 4'b1000, 3'd3, 0, 0});
        rv.push_back('{1, 0, 0, 0, 4'b0000, 4'b0001, 3'd0, 1, 0});
        rv.push_back('{1, 1, 0, 0, 4'b0000, 4'b1000, 3'd3, 1, 0});
        rv.push_back('{0, 0, 0, 1, 4'b0100, 4'b0100, 3'd2, 0, 0});
        rv.push_back('{1, 0, 0, 1, 4'b0110, 4'b0100, 3'd2, 0, 1});
        rv.push_back('{0, 0, 0, 1, 4'b0000, 4'b0100, 3'd2, 0, 1});
        rv.push_back('{1, 0, 1, 1, 4'b1000, 4'b0001, 3'd0, 0, 0});

        drive_j(idle);
        drive_r(idle);
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_j_q",    32'(bus_j.q),    32'h0);
        check("rst_j_idx",  32'(bus_j.idx),  32'h0);
        check("rst_j_wrap", 32'(bus_j.wrap), 32'h0);
        check("rst_j_err",  32'(bus_j.err),  32'h0);
        check("rst_r_q",    32'(bus_r.q),    32'h1);
        check("rst_r_idx",  32'(bus_r.idx),  32'h0);
        n_rst = 1'b1;

        for (int i = 0; i < jv.size(); i++) begin
            @(negedge clk);
            drive_j(jv[i]);
            @(posedge clk);
            #1;
            check($sformatf("j%0d_q", i),    32'(bus_j.q),    32'(jv[i].q));
            check($sformatf("j%0d_idx", i),  32'(bus_j.idx),  32'(jv[i].idx));
            check($sformatf("j%0d_wrap", i), 32'(bus_j.wrap), 32'(jv[i].wrap));
            check($sformatf("j%0d_err", i),  32'(bus_j.err),  32'(jv[i].err));
        end

        for (int i = 0; i < rv.size(); i++) begin
            @(negedge clk);
            drive_j(idle);
            drive_r(rv[i]);
            @(posedge clk);
            #1;
            check($sformatf("r%0d_q", i),    32'(bus_r.q),    32'(rv[i].q));
            check($sformatf("r%0d_idx", i),  32'(bus_r.idx),  32'(rv[i].idx));
            check($sformatf("r%0d_wrap", i), 32'(bus_r.wrap), 32'(rv[i].wrap));
            check($sformatf("r%0d_err", i),  32'(bus_r.err),  32'(rv[i].err));
        end
        @(negedge clk);
        drive_r(idle);

        // Forced illegal Johnson pattern with en low is corrected next edge.
        @(negedge clk);
        force dut_j.q_r = 4'b0101;
        #1;
        release dut_j.q_r;
        @(posedge clk);
        #1;
        check("corr_q",    32'(bus_j.q),    32'h0);
        check("corr_idx",  32'(bus_j.idx),  32'h0);
        check("corr_err",  32'(bus_j.err),  32'h1);
        check("corr_wrap", 32'(bus_j.wrap), 32'h0);

        // Mid-count asynchronous reset at q = 0111.
        @(negedge clk);
        bus_j.clr = 1'b1;
        @(negedge clk);
        bus_j.clr = 1'b0;
        bus_j.en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_q", 32'(bus_j.q), 32'h7);
        #1;
        n_rst = 1'b0;
        #1;
        check("arst_q",    32'(bus_j.q),    32'h0);
        check("arst_idx",  32'(bus_j.idx),  32'h0);
        check("arst_wrap", 32'(bus_j.wrap), 32'h0);
        check("arst_r_q",  32'(bus_r.q),    32'h1);
        @(posedge clk);
        #1;
        check("arst_hold_q", 32'(bus_j.q), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_q",   32'(bus_j.q),   32'h1);
        check("post_rst_idx", 32'(bus_j.idx), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
